rubiks_polibot_uc: RTL and testbench
====================================

# rubiks_polibot_uc

Control unit for the Rubik's Polibot datapath. It sequences the whole solve: capture and colour-identify six faces, transmit the colours, reorient the cube between faces, receive the solution, and replay it through the servo manager. It drives the datapath's strobe, counter and serial-select inputs and reacts to its handshake outputs. It is one Moore FSM with one-cycle command pulses.

## Interface
- `TIMEOUT`, default 50_000_000: cycle limit per wait state (1 s at 50 MHz); used only when the watchdog is compiled in.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `iniciar`  in  1  start request, sampled in INICIAL and FINAL.
- `imagem_recebida`, `cores_identificadas`, `cores_transmitidas`, `movimentos_recebidos`  in  1 each  done flags from the capture, identify, colour-tx and move-rx sub-blocks.
- `servo_pronto`  in  1  servo manager finished the current move.
- `fim_face`  in  1  face counter at 5.
- `meio_face`  in  1  face counter at 2.
- `fim_movimentos`  in  1  move counter at 479.
- `movimento`  in  3  move code read from the move RAM.
- `zera_face`, `zera_movimento`, `conta_face`, `conta_movimento`  out  1 each  counter controls.
- `captura_imagem`, `identificar_cores`, `enviar_cores`, `obter_movimentos`, `aciona_movimento`  out  1 each  one-cycle start pulses.
- `sel_mov_fixo`  out  1  servo manager takes `mov_fixo` instead of the RAM move.
- `mov_fixo`  out  3  reorientation move code.
- `sel_serial1`, `sel_serial2`  out  1 each  serial mux select: 00 image, 10 colours, 11 moves.
- `pronto`  out  1  solve finished.
- `erro`  out  1  watchdog fired.
- `db_estado`  out  5  current state code.

Reset values: every output is 0, and `db_estado` = INICIAL (5'h00).

## Operation
- INICIAL (00): on `iniciar`, go to PREPARA.
- PREPARA (01): assert `zera_face` and `zera_movimento`; go to CAPTURA.
- CAPTURA (02): pulse `captura_imagem`; go to ESPERA_IMAGEM.
- ESPERA_IMAGEM (03): wait for `imagem_recebida`, then go to IDENTIFICA.
- IDENTIFICA (04): pulse `identificar_cores`; go to ESPERA_CORES.
- ESPERA_CORES (05): wait for `cores_identificadas`, then go to TRANSMITE.
- TRANSMITE (06): pulse `enviar_cores`; go to ESPERA_TX.
- ESPERA_TX (07): wait for `cores_transmitidas`, then go to PROXIMA_FACE.
- PROXIMA_FACE (08): assert `conta_face`.
  - If `fim_face` (sampled before the increment), go to OBTEM.
  - Otherwise go to REPOSICIONA.
- REPOSICIONA (09): assert `sel_mov_fixo`; pulse `aciona_movimento`.
  - `mov_fixo` = MOV_GIRA_BASE if `meio_face`, else MOV_TOMBA.
  - Go to ESPERA_REPOS.
- ESPERA_REPOS (0A): hold `sel_mov_fixo`; wait for `servo_pronto`, then go to CAPTURA.
- OBTEM (0B): pulse `obter_movimentos`; go to ESPERA_MOV.
- ESPERA_MOV (0C): wait for `movimentos_recebidos`, then go to LE_MOV.
- LE_MOV (0D): one-cycle RAM read slot; go to EXECUTA.
- EXECUTA (0E):
  - If `movimento` == MOV_FIM (3'b111), go to FINAL.
  - Otherwise pulse `aciona_movimento` and go to ESPERA_EXEC.
- ESPERA_EXEC (0F): wait for `servo_pronto`.
  - If `fim_movimentos`, go to FINAL.
  - Otherwise assert `conta_movimento` and go to LE_MOV.
- FINAL (10): `pronto` = 1; on `iniciar`, go to PREPARA.
- ERRO (1F): `erro` = 1; leave only on `reset`.
- Serial selects:
  - `sel_serial1` = 1 in states 06–07 and 0B–0C.
  - `sel_serial2` = 1 in states 0B–0C only.
  - 00 everywhere else.
- `iniciar` is ignored outside INICIAL and FINAL.

## Timing
- All outputs are decoded from the state register, so they are valid in the same cycle as the state.
- Done inputs are level-sampled; the transition occurs on the next rising edge.
- A done flag already high on entry to a wait state is accepted at the first edge.
- Latency from `iniciar` to the first `captura_imagem` pulse: 2 cycles.
- One reorientation costs 2 cycles plus the servo time.
- One move costs 3 cycles plus the servo time.
- Six faces produce exactly 5 reorientations and 6 `conta_face` pulses.
- The move list ends on MOV_FIM or after address 479, whichever comes first. Address 479 is still executed.
- Asserting `reset` mid-operation returns to INICIAL at once and drops every pulse, with no partial outputs.

## Configuration
- `UC_WATCHDOG_EN` defined:
  - A counter clears on every state change.
  - It runs in every wait state (03, 05, 07, 0A, 0C, 0F).
  - When it reaches `TIMEOUT`−1 without the done flag, the next state is ERRO.
- `UC_WATCHDOG_EN` undefined: no counter, ERRO is unreachable, and `erro` is tied to 0.

## Structure
- Package `rubiks_polibot_pkg` holds:
  - the 5-bit state encodings;
  - the move codes MOV_TOMBA, MOV_GIRA_BASE and MOV_FIM;
  - the default `TIMEOUT`.
- Sub-module `uc_watchdog`: clear/enable counter with a `expirou` flag, instantiated only under `UC_WATCHDOG_EN`.

## Test plan
- Full run with every done flag returned 3 cycles after its pulse and `movimento` = MOV_FIM at address 4:
  - 6 `captura_imagem` pulses and 5 reorientations (the 3rd uses MOV_GIRA_BASE, the others MOV_TOMBA);
  - 4 RAM-driven `aciona_movimento` pulses;
  - `pronto` = 1 and `db_estado` = 10.
- `servo_pronto` held high throughout → each move takes exactly 3 cycles; 4 `conta_movimento` pulses before FINAL.
- No MOV_FIM in the list → 480 moves executed; FINAL reached after address 479 without a 480th `conta_movimento`.
- `reset` pulsed while in ESPERA_TX → next cycle `db_estado` = 00, all outputs 0, `sel_serial` = 00.
- `UC_WATCHDOG_EN` on, `TIMEOUT` = 16, `imagem_recebida` never asserted → ERRO 16 cycles after entering 03; `erro` = 1 until `reset`.
- `iniciar` held high in ESPERA_CORES → no effect. `iniciar` in FINAL → PREPARA with `zera_face` and `zera_movimento` = 1.

Source files
------------

// File: rtl/rubiks_polibot_uc_pkg.sv
// rtl/rubiks_polibot_uc_pkg.sv - state codes, move codes and defaults for the Polibot control unit
// Purpose: shared definitions for rubiks_polibot_uc and its watchdog.
//   estado_t        : 5-bit state encodings, visible on db_estado
//   MOV_*           : move codes for reorientation and list termination
//   TIMEOUT_DEFAULT : cycles allowed per wait state (1 s at 50 MHz)
//   is_espera()     : true for the states that wait on a done flag
package rubiks_polibot_pkg;

  typedef enum logic [4:0] {
    ST_INICIAL       = 5'h00,
    ST_PREPARA       = 5'h01,
    ST_CAPTURA       = 5'h02,
    ST_ESPERA_IMAGEM = 5'h03,
    ST_IDENTIFICA    = 5'h04,
    ST_ESPERA_CORES  = 5'h05,
    ST_TRANSMITE     = 5'h06,
    ST_ESPERA_TX     = 5'h07,
    ST_PROXIMA_FACE  = 5'h08,
    ST_REPOSICIONA   = 5'h09,
    ST_ESPERA_REPOS  = 5'h0A,
    ST_OBTEM         = 5'h0B,
    ST_ESPERA_MOV    = 5'h0C,
    ST_LE_MOV        = 5'h0D,
    ST_EXECUTA       = 5'h0E,
    ST_ESPERA_EXEC   = 5'h0F,
    ST_FINAL         = 5'h10,
    ST_ERRO          = 5'h1F
  } estado_t;

  localparam logic [2:0] MOV_TOMBA     = 3'b001;
  localparam logic [2:0] MOV_GIRA_BASE = 3'b010;
  localparam logic [2:0] MOV_FIM       = 3'b111;

  localparam int TIMEOUT_DEFAULT = 50_000_000;

  function automatic logic is_espera(input estado_t s);
    return s inside {ST_ESPERA_IMAGEM, ST_ESPERA_CORES, ST_ESPERA_TX,
                     ST_ESPERA_REPOS, ST_ESPERA_MOV, ST_ESPERA_EXEC};
  endfunction

endpackage

// File: rtl/rubiks_polibot_uc_if.sv
// rtl/rubiks_polibot_uc_if.sv - handshake bundle between the control unit and the Polibot datapath
// Purpose: groups every control-unit <-> datapath signal.
//   master : control unit side (takes done flags/counter status, drives strobes)
//   slave  : datapath side
interface rubiks_polibot_uc_if;
  import rubiks_polibot_pkg::*;

  logic       iniciar;
  logic       imagem_recebida;
  logic       cores_identificadas;
  logic       cores_transmitidas;
  logic       movimentos_recebidos;
  logic       servo_pronto;
  logic       fim_face;
  logic       meio_face;
  logic       fim_movimentos;
  logic [2:0] movimento;

  logic       zera_face;
  logic       zera_movimento;
  logic       conta_face;
  logic       conta_movimento;
  logic       captura_imagem;
  logic       identificar_cores;
  logic       enviar_cores;
  logic       obter_movimentos;
  logic       aciona_movimento;
  logic       sel_mov_fixo;
  logic [2:0] mov_fixo;
  logic       sel_serial1;
  logic       sel_serial2;
  logic       pronto;
  logic       erro;
  logic [4:0] db_estado;

  modport master (
    input  iniciar, imagem_recebida, cores_identificadas, cores_transmitidas,
           movimentos_recebidos, servo_pronto, fim_face, meio_face,
           fim_movimentos, movimento,
    output zera_face, zera_movimento, conta_face, conta_movimento,
           captura_imagem, identificar_cores, enviar_cores, obter_movimentos,
           aciona_movimento, sel_mov_fixo, mov_fixo, sel_serial1, sel_serial2,
           pronto, erro, db_estado
  );

  modport slave (
    output iniciar, imagem_recebida, cores_identificadas, cores_transmitidas,
           movimentos_recebidos, servo_pronto, fim_face, meio_face,
           fim_movimentos, movimento,
    input  zera_face, zera_movimento, conta_face, conta_movimento,
           captura_imagem, identificar_cores, enviar_cores, obter_movimentos,
           aciona_movimento, sel_mov_fixo, mov_fixo, sel_serial1, sel_serial2,
           pronto, erro, db_estado
  );
endinterface

// File: rtl/rubiks_polibot_uc_watchdog.sv
// rtl/rubiks_polibot_uc_watchdog.sv - per-wait-state timeout counter for the Polibot control unit
// Purpose: counts cycles spent in a wait state.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   i_clr        : restart the count (held while not waiting)
//   i_en         : count this cycle
//   o_expirou    : count reached TIMEOUT-1 while enabled
module uc_watchdog
  import rubiks_polibot_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expirou
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  assign o_expirou = i_en && (r_cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expirou) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rubiks_polibot_uc.sv
// rtl/rubiks_polibot_uc.sv - Moore control unit sequencing the Rubik's Polibot solve
// Purpose: captures and identifies six faces, transmits colours, reorients the
// cube between faces, receives the solution and replays it through the servos.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : rubiks_polibot_uc_if.master (done flags in, strobes/selects out)
//   TIMEOUT      : cycles allowed per wait state when the watchdog is built
// Optional feature: define UC_WATCHDOG_EN to build the wait-state watchdog and
// the ERRO state; otherwise erro is tied low.
module rubiks_polibot_uc
  import rubiks_polibot_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  rubiks_polibot_uc_if.master  bus
);

  estado_t    r_estado;
  logic [2:0] r_mov_fixo;
  logic       w_expirou;

`ifdef UC_WATCHDOG_EN
  logic w_espera;
  assign w_espera = is_espera(r_estado);

  // Every wait state is entered from a non-wait state, so clearing while not
  // waiting restarts the count on every state change.
  uc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (~w_espera),
    .i_en      (w_espera),
    .o_expirou (w_expirou)
  );
`else
  // Never expires; TIMEOUT is referenced so both builds share one parameter list.
  assign w_expirou = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= ST_INICIAL;
      r_mov_fixo <= '0;
    end else begin
      case (r_estado)
        ST_INICIAL:       if (bus.iniciar) r_estado <= ST_PREPARA;
        ST_PREPARA:       r_estado <= ST_CAPTURA;
        ST_CAPTURA:       r_estado <= ST_ESPERA_IMAGEM;
        ST_ESPERA_IMAGEM: if (bus.imagem_recebida) r_estado <= ST_IDENTIFICA;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_IDENTIFICA:    r_estado <= ST_ESPERA_CORES;
        ST_ESPERA_CORES:  if (bus.cores_identificadas) r_estado <= ST_TRANSMITE;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_TRANSMITE:     r_estado <= ST_ESPERA_TX;
        ST_ESPERA_TX:     if (bus.cores_transmitidas) r_estado <= ST_PROXIMA_FACE;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_PROXIMA_FACE: begin
          // meio_face is captured here, before the face counter increments,
          // so the third reorientation is the base turn.
          r_mov_fixo <= bus.meio_face ? MOV_GIRA_BASE : MOV_TOMBA;
          r_estado   <= bus.fim_face ? ST_OBTEM : ST_REPOSICIONA;
        end
        ST_REPOSICIONA:   r_estado <= ST_ESPERA_REPOS;
        ST_ESPERA_REPOS:  if (bus.servo_pronto) r_estado <= ST_CAPTURA;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_OBTEM:         r_estado <= ST_ESPERA_MOV;
        ST_ESPERA_MOV:    if (bus.movimentos_recebidos) r_estado <= ST_LE_MOV;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_LE_MOV:        r_estado <= ST_EXECUTA;
        ST_EXECUTA:       r_estado <= (bus.movimento == MOV_FIM) ? ST_FINAL : ST_ESPERA_EXEC;
        ST_ESPERA_EXEC:   if (bus.servo_pronto) r_estado <= bus.fim_movimentos ? ST_FINAL : ST_LE_MOV;
                          else if (w_expirou) r_estado <= ST_ERRO;
        ST_FINAL:         if (bus.iniciar) r_estado <= ST_PREPARA;
        ST_ERRO:          r_estado <= ST_ERRO;
        default:          r_estado <= ST_INICIAL;
      endcase
    end
  end

  always_comb begin
    bus.zera_face         = 1'b0;
    bus.zera_movimento    = 1'b0;
    bus.conta_face        = 1'b0;
    bus.conta_movimento   = 1'b0;
    bus.captura_imagem    = 1'b0;
    bus.identificar_cores = 1'b0;
    bus.enviar_cores      = 1'b0;
    bus.obter_movimentos  = 1'b0;
    bus.aciona_movimento  = 1'b0;
    bus.sel_mov_fixo      = 1'b0;
    bus.mov_fixo          = 3'b000;
    bus.sel_serial1       = 1'b0;
    bus.sel_serial2       = 1'b0;
    bus.pronto            = 1'b0;
    bus.erro              = 1'b0;
    bus.db_estado         = r_estado;
    case (r_estado)
      ST_PREPARA:      begin bus.zera_face = 1'b1; bus.zera_movimento = 1'b1; end
      ST_CAPTURA:      bus.captura_imagem = 1'b1;
      ST_IDENTIFICA:   bus.identificar_cores = 1'b1;
      ST_TRANSMITE:    begin bus.enviar_cores = 1'b1; bus.sel_serial1 = 1'b1; end
      ST_ESPERA_TX:    bus.sel_serial1 = 1'b1;
      ST_PROXIMA_FACE: bus.conta_face = 1'b1;
      ST_REPOSICIONA: begin
        bus.sel_mov_fixo     = 1'b1;
        bus.mov_fixo         = r_mov_fixo;
        bus.aciona_movimento = 1'b1;
      end
      ST_ESPERA_REPOS: begin bus.sel_mov_fixo = 1'b1; bus.mov_fixo = r_mov_fixo; end
      ST_OBTEM: begin
        bus.obter_movimentos = 1'b1;
        bus.sel_serial1      = 1'b1;
        bus.sel_serial2      = 1'b1;
      end
      ST_ESPERA_MOV:   begin bus.sel_serial1 = 1'b1; bus.sel_serial2 = 1'b1; end
      // The RAM word is valid after the LE_MOV read slot; MOV_FIM ends the list
      // without driving the servos.
      ST_EXECUTA:      bus.aciona_movimento = (bus.movimento != MOV_FIM);
      // Advance the address only when another move will follow.
      ST_ESPERA_EXEC:  bus.conta_movimento = bus.servo_pronto & ~bus.fim_movimentos;
      ST_FINAL:        bus.pronto = 1'b1;
`ifdef UC_WATCHDOG_EN
      ST_ERRO:         bus.erro = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rubiks_polibot_uc.sv
// tb/tb_rubiks_polibot_uc.sv - self-checking bench for rubiks_polibot_uc
module tb_rubiks_polibot_uc;
  import rubiks_polibot_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rubiks_polibot_uc_if bus();
  rubiks_polibot_uc #(.TIMEOUT(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  int         face_cnt = 0;
  int         mov_cnt  = 0;
  logic [2:0] ram [0:479];
  int         delay_d  = 3;
  bit         servo_hold = 0, hold_img = 0, hold_cores = 0;
  int         c_img = 0, c_cor = 0, c_tx = 0, c_mv = 0, c_sv = 0;
  logic       f_img = 0, f_cor = 0, f_tx = 0, f_mv = 0, f_sv = 0;

  always @(posedge clock) begin
    if (bus.zera_face) face_cnt <= 0;
    else if (bus.conta_face) face_cnt <= face_cnt + 1;
    if (bus.zera_movimento) mov_cnt <= 0;
    else if (bus.conta_movimento) mov_cnt <= mov_cnt + 1;
  end

  // Each done flag rises delay_d cycles after its start pulse and drops on the next pulse.
  always @(posedge clock) begin
    if (bus.captura_imagem) begin f_img <= 0; c_img <= delay_d - 1; end
    else if (c_img == 1) begin f_img <= 1; c_img <= 0; end
    else if (c_img > 1) c_img <= c_img - 1;
    if (bus.identificar_cores) begin f_cor <= 0; c_cor <= delay_d - 1; end
    else if (c_cor == 1) begin f_cor <= 1; c_cor <= 0; end
    else if (c_cor > 1) c_cor <= c_cor - 1;
    if (bus.enviar_cores) begin f_tx <= 0; c_tx <= delay_d - 1; end
    else if (c_tx == 1) begin f_tx <= 1; c_tx <= 0; end
    else if (c_tx > 1) c_tx <= c_tx - 1;
    if (bus.obter_movimentos) begin f_mv <= 0; c_mv <= delay_d - 1; end
    else if (c_mv == 1) begin f_mv <= 1; c_mv <= 0; end
    else if (c_mv > 1) c_mv <= c_mv - 1;
    if (bus.aciona_movimento) begin f_sv <= 0; c_sv <= delay_d - 1; end
    else if (c_sv == 1) begin f_sv <= 1; c_sv <= 0; end
    else if (c_sv > 1) c_sv <= c_sv - 1;
  end

  assign bus.imagem_recebida      = f_img & ~hold_img;
  assign bus.cores_identificadas  = f_cor & ~hold_cores;
  assign bus.cores_transmitidas   = f_tx;
  assign bus.movimentos_recebidos = f_mv;
  assign bus.servo_pronto         = servo_hold | f_sv;
  assign bus.fim_face             = (face_cnt == 5);
  assign bus.meio_face            = (face_cnt == 2);
  assign bus.fim_movimentos       = (mov_cnt == 479);
  assign bus.movimento            = (mov_cnt < 480) ? ram[mov_cnt] : MOV_FIM;

  // ---------------- event monitor ----------------
  int         n_cface = 0, n_cmov = 0, sel_bad = 0, erro_seen = 0;
  int         cap_cyc[$], repos_cyc[$], ram_ac_cyc[$];
  logic [2:0] repos_codes[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.captura_imagem) begin
        cap_cyc.push_back(cyc);
        if ({bus.sel_serial1, bus.sel_serial2} != 2'b00) sel_bad++;
      end
      if (bus.aciona_movimento) begin
        if (bus.sel_mov_fixo) begin repos_codes.push_back(bus.mov_fixo); repos_cyc.push_back(cyc); end
        else ram_ac_cyc.push_back(cyc);
      end
      if (bus.conta_face) n_cface++;
      if (bus.conta_movimento) n_cmov++;
      if (bus.enviar_cores && {bus.sel_serial1, bus.sel_serial2} != 2'b10) sel_bad++;
      if (bus.obter_movimentos && {bus.sel_serial1, bus.sel_serial2} != 2'b11) sel_bad++;
      if (bus.erro) erro_seen++;
    end
  end

  function automatic logic [16:0] outs();
    return {bus.zera_face, bus.zera_movimento, bus.conta_face, bus.conta_movimento,
            bus.captura_imagem, bus.identificar_cores, bus.enviar_cores, bus.obter_movimentos,
            bus.aciona_movimento, bus.sel_mov_fixo, bus.mov_fixo, bus.sel_serial1,
            bus.sel_serial2, bus.pronto, bus.erro};
  endfunction

  task automatic clear_log();
    cap_cyc.delete(); repos_cyc.delete(); ram_ac_cyc.delete(); repos_codes.delete();
    n_cface = 0; n_cmov = 0; sel_bad = 0;
  endtask

  task automatic wait_state(input logic [4:0] s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.db_estado == s) begin ok = 1; break; end
    end
  endtask

  task automatic fill_ram(input int fim_addr);
    for (int i = 0; i < 480; i++) ram[i] = 3'($urandom_range(0, 6));
    if (fim_addr < 480) ram[fim_addr] = MOV_FIM;
  endtask

  // Runs one complete solve and compares against counts/timings derived from the rules.
  task automatic run_solve(input int fim_addr, input int d, input bit hold, input string tag);
    bit ok; int start, exp_moves, exp_cmov, bad, exp_rep;
    fill_ram(fim_addr);
    delay_d = d; servo_hold = hold;
    clear_log();
    @(negedge clock);
    start = cyc; bus.iniciar = 1;
    @(negedge clock);
    bus.iniciar = 0;
    wait_state(5'h10, 8000, ok);
    exp_moves = (fim_addr < 480) ? fim_addr : 480;
    exp_cmov  = (fim_addr < 480) ? fim_addr : 479;
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL %s final_reached got %0d want 1", tag, ok); end
    checks++; if (cap_cyc.size() != 6) begin fails++; $display("FAIL %s captures got %0d want 6", tag, cap_cyc.size()); end
    if (cap_cyc.size() > 0) begin
      checks++; if (cap_cyc[0] - start != 2) begin fails++; $display("FAIL %s start_latency got %0d want 2", tag, cap_cyc[0] - start); end
    end
    checks++; if (repos_codes.size() != 5) begin fails++; $display("FAIL %s reorients got %0d want 5", tag, repos_codes.size()); end
    bad = 0;
    for (int i = 0; i < repos_codes.size() && i < 5; i++)
      if (repos_codes[i] !== ((i == 2) ? MOV_GIRA_BASE : MOV_TOMBA)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL %s reorient_codes got %0d wrong want 0", tag, bad); end
    bad = 0; exp_rep = hold ? 2 : d + 1;
    for (int i = 0; i < repos_cyc.size() && i + 1 < cap_cyc.size(); i++)
      if (cap_cyc[i+1] - repos_cyc[i] != exp_rep) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL %s reorient_time got %0d wrong want 0 (each %0d)", tag, bad, exp_rep); end
    checks++; if (n_cface != 6) begin fails++; $display("FAIL %s conta_face got %0d want 6", tag, n_cface); end
    checks++; if (ram_ac_cyc.size() != exp_moves) begin fails++; $display("FAIL %s ram_moves got %0d want %0d", tag, ram_ac_cyc.size(), exp_moves); end
    checks++; if (n_cmov != exp_cmov) begin fails++; $display("FAIL %s conta_movimento got %0d want %0d", tag, n_cmov, exp_cmov); end
    checks++; if (sel_bad != 0) begin fails++; $display("FAIL %s serial_select got %0d bad want 0", tag, sel_bad); end
    checks++; if (bus.pronto !== 1'b1 || bus.db_estado !== 5'h10) begin
      fails++; $display("FAIL %s end_state got pronto=%0b estado=%h want 1/10", tag, bus.pronto, bus.db_estado); end
    if (hold && ram_ac_cyc.size() >= 2) begin
      bad = 0;
      for (int i = 1; i < ram_ac_cyc.size(); i++) if (ram_ac_cyc[i] - ram_ac_cyc[i-1] != 3) bad++;
      checks++; if (bad != 0) begin fails++; $display("FAIL %s move_period got %0d wrong want 0 (each 3)", tag, bad); end
    end
  endtask

  task automatic test_reset();
    reset = 1; bus.iniciar = 0;
    repeat (3) @(negedge clock);
    checks++; if (bus.db_estado !== 5'h00) begin fails++; $display("FAIL reset_state got %h want 00", bus.db_estado); end
    checks++; if (outs() !== 17'h0) begin fails++; $display("FAIL reset_outputs got %h want 0", outs()); end
    reset = 0;
    @(negedge clock);
    checks++; if (bus.db_estado !== 5'h00) begin fails++; $display("FAIL idle_state got %h want 00", bus.db_estado); end
  endtask

  task automatic test_full_run();
    run_solve(4, 3, 0, "full_run");
  endtask

  task automatic test_servo_hold();
    run_solve(4, 3, 1, "servo_hold");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      run_solve(int'($urandom_range(0, 40)), int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_no_fim();
    run_solve(480, 2, 1, "no_fim");
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_ram(3); delay_d = 4; servo_hold = 0;
    @(negedge clock); bus.iniciar = 1;
    @(negedge clock); bus.iniciar = 0;
    wait_state(5'h07, 200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL reset_mid reach_tx got %0d want 1", ok); end
    reset = 1;
    #1;
    checks++; if (bus.db_estado !== 5'h00 || outs() !== 17'h0) begin
      fails++; $display("FAIL reset_mid async got estado=%h outs=%h want 00/0", bus.db_estado, outs()); end
    @(negedge clock);
    checks++; if (bus.db_estado !== 5'h00 || outs() !== 17'h0) begin
      fails++; $display("FAIL reset_mid next got estado=%h outs=%h want 00/0", bus.db_estado, outs()); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_iniciar();
    bit ok, moved;
    fill_ram(2); delay_d = 3; servo_hold = 1; hold_cores = 1;
    bus.iniciar = 1; @(negedge clock); bus.iniciar = 0;
    wait_state(5'h05, 200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL iniciar reach_cores got %0d want 1", ok); end
    bus.iniciar = 1; moved = 0;
    repeat (6) begin @(negedge clock); if (bus.db_estado !== 5'h05) moved = 1; end
    checks++; if (moved !== 1'b0) begin fails++; $display("FAIL iniciar_ignored got moved=%0b want 0", moved); end
    bus.iniciar = 0; hold_cores = 0;
    wait_state(5'h10, 1000, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL iniciar reach_final got %0d want 1", ok); end
    bus.iniciar = 1; @(negedge clock); bus.iniciar = 0;
    checks++; if (bus.db_estado !== 5'h01 || bus.zera_face !== 1'b1 || bus.zera_movimento !== 1'b1) begin
      fails++; $display("FAIL restart got estado=%h zf=%0b zm=%0b want 01/1/1", bus.db_estado, bus.zera_face, bus.zera_movimento); end
    wait_state(5'h10, 1000, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL restart reach_final got %0d want 1", ok); end
  endtask

  task automatic test_watchdog();
`ifdef UC_WATCHDOG_EN
    bit ok, left; int t3, terr;
    hold_img = 1; delay_d = 3;
    bus.iniciar = 1; @(negedge clock); bus.iniciar = 0;
    wait_state(5'h03, 50, ok); t3 = cyc;
    wait_state(5'h1F, 60, ok); terr = cyc;
    checks++; if (ok !== 1'b1 || terr - t3 != 16) begin
      fails++; $display("FAIL watchdog_time got ok=%0b dt=%0d want 1/16", ok, terr - t3); end
    hold_img = 0; left = 0;
    repeat (20) begin @(negedge clock); if (bus.db_estado !== 5'h1F || bus.erro !== 1'b1) left = 1; end
    checks++; if (left !== 1'b0) begin fails++; $display("FAIL watchdog_hold got left=%0b want 0", left); end
    reset = 1; @(negedge clock); reset = 0; @(negedge clock);
    checks++; if (bus.db_estado !== 5'h00 || bus.erro !== 1'b0) begin
      fails++; $display("FAIL watchdog_reset got estado=%h erro=%0b want 00/0", bus.db_estado, bus.erro); end
`else
    checks++; if (erro_seen != 0) begin fails++; $display("FAIL erro_tied got %0d cycles want 0", erro_seen); end
`endif
  endtask

  initial begin
    bus.iniciar = 0;
    test_reset();
    test_full_run();
    test_servo_hold();
    test_random();
    test_no_fim();
    test_reset_mid();
    test_iniciar();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
